// File: rtl/ball_motion.sv
// Ball stage of the Pong datapath: position, bounces, scoring and serve timing.
// All motion advances on the 1 ms game tick.
module ball_motion #(
    parameter int H_ACTIVE      = 640,
    parameter int V_ACTIVE      = 480,
    parameter int BALL_HALF     = 4,
    parameter int PADDLE_HALF_W = 3,
    parameter int PADDLE_HALF_H = 30,
    parameter int SERVE_TICKS   = 1000,
    parameter int WIN_SCORE     = 7
) (
    input  logic        clk_1ms,
    input  logic        reset,
    input  logic        switch,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic [9:0]  x_paddle1,
    input  logic [9:0]  y_paddle1,
    input  logic [9:0]  x_paddle2,
    input  logic [9:0]  y_paddle2,
    output logic        ball_on,
    output logic [11:0] rgb_ball,
    output logic [9:0]  x_ball,
    output logic [9:0]  y_ball,
    output logic [3:0]  score1,
    output logic [3:0]  score2,
    output logic        point_p1,
    output logic        point_p2,
    output logic        game_over
);
    typedef enum logic [1:0] {S_SERVE, S_PLAY, S_SCORED, S_OVER} state_t;

    localparam int         CW    = $clog2(SERVE_TICKS + 1);
    localparam logic [9:0] X_MID = 10'(H_ACTIVE / 2);
    localparam logic [9:0] Y_MID = 10'(V_ACTIVE / 2);
    localparam logic [3:0] WIN   = 4'(WIN_SCORE);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0]    x_ball_q, x_ball_d, y_ball_q, y_ball_d;
    logic          dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [3:0]    score1_q, score1_d, score2_q, score2_d;
    logic          point_p1_q, point_p1_d, point_p2_q, point_p2_d;
    logic          game_over_q, game_over_d;

    logic [10:0] l, r, t, b;
    logic        ov1, ov2, hit1, hit2, miss_l, miss_r, wall_t, wall_b;

    assign l = {1'b0, x_ball_q} - 11'(BALL_HALF);
    assign r = {1'b0, x_ball_q} + 11'(BALL_HALF);
    assign t = {1'b0, y_ball_q} - 11'(BALL_HALF);
    assign b = {1'b0, y_ball_q} + 11'(BALL_HALF);

    // Paddle terms moved to the other side so nothing can underflow
    assign ov1 = (b + 11'(PADDLE_HALF_H) > {1'b0, y_paddle1}) &&
                 (t < {1'b0, y_paddle1} + 11'(PADDLE_HALF_H));
    assign ov2 = (b + 11'(PADDLE_HALF_H) > {1'b0, y_paddle2}) &&
                 (t < {1'b0, y_paddle2} + 11'(PADDLE_HALF_H));

    assign hit1   = !dir_x_q && ov1 &&
                    (l == {1'b0, x_paddle1} + 11'(PADDLE_HALF_W + 1));
    assign hit2   = dir_x_q && ov2 &&
                    (r + 11'(PADDLE_HALF_W + 1) == {1'b0, x_paddle2});
    assign miss_l = !dir_x_q && (l == 11'd0);
    assign miss_r = dir_x_q && (r == 11'(H_ACTIVE - 1));
    assign wall_t = !dir_y_q && (t == 11'd0);
    assign wall_b = dir_y_q && (b == 11'(V_ACTIVE - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        x_ball_d    = x_ball_q;
        y_ball_d    = y_ball_q;
        dir_x_d     = dir_x_q;
        dir_y_d     = dir_y_q;
        score1_d    = score1_q;
        score2_d    = score2_q;
        point_p1_d  = 1'b0;
        point_p2_d  = 1'b0;
        game_over_d = game_over_q;
        if (!switch) begin
            unique case (state_q)
                S_SERVE: begin
                    x_ball_d = X_MID;
                    y_ball_d = Y_MID;
                    if (cnt_q == CW'(SERVE_TICKS - 1)) begin
                        cnt_d   = '0;
                        state_d = S_PLAY;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_PLAY: begin
                    if (miss_l) begin
                        if (score2_q < WIN) score2_d = score2_q + 4'd1;
                        point_p2_d = 1'b1;
                        state_d    = S_SCORED;
                    end else if (miss_r) begin
                        if (score1_q < WIN) score1_d = score1_q + 4'd1;
                        point_p1_d = 1'b1;
                        state_d    = S_SCORED;
                    end else begin
                        dir_x_d  = hit1 ? 1'b1 : (hit2 ? 1'b0 : dir_x_q);
                        dir_y_d  = wall_t ? 1'b1 : (wall_b ? 1'b0 : dir_y_q);
                        x_ball_d = dir_x_d ? x_ball_q + 10'd1 : x_ball_q - 10'd1;
                        y_ball_d = dir_y_d ? y_ball_q + 10'd1 : y_ball_q - 10'd1;
                    end
                end
                S_SCORED: begin
                    // dir_x still points at the losing side, so keeping it serves toward them
                    x_ball_d = X_MID;
                    y_ball_d = Y_MID;
                    if (score1_q == WIN || score2_q == WIN) begin
                        state_d     = S_OVER;
                        game_over_d = 1'b1;
                    end else begin
                        state_d = S_SERVE;
                    end
                end
                S_OVER: begin
                    x_ball_d    = X_MID;
                    y_ball_d    = Y_MID;
                    game_over_d = 1'b1;
                end
                default: state_d = S_SERVE;
            endcase
        end
    end

    always_ff @(posedge clk_1ms or posedge reset) begin
        if (reset) begin
            state_q     <= S_SERVE;
            cnt_q       <= '0;
            x_ball_q    <= X_MID;
            y_ball_q    <= Y_MID;
            dir_x_q     <= 1'b1;
            dir_y_q     <= 1'b1;
            score1_q    <= '0;
            score2_q    <= '0;
            point_p1_q  <= 1'b0;
            point_p2_q  <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_ball_q    <= x_ball_d;
            y_ball_q    <= y_ball_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            score1_q    <= score1_d;
            score2_q    <= score2_d;
            point_p1_q  <= point_p1_d;
            point_p2_q  <= point_p2_d;
            game_over_q <= game_over_d;
        end
    end

    assign ball_on   = (state_q != S_OVER) &&
                       ({1'b0, x} >= l) && ({1'b0, x} < r) &&
                       ({1'b0, y} >= t) && ({1'b0, y} < b);
    assign rgb_ball  = 12'hFF0;
    assign x_ball    = x_ball_q;
    assign y_ball    = y_ball_q;
    assign score1    = score1_q;
    assign score2    = score2_q;
    assign point_p1  = point_p1_q;
    assign point_p2  = point_p2_q;
    assign game_over = game_over_q;
endmodule

// File: doc/ball_motion.md
# ball_motion

Ball stage of the Pong datapath. It sits directly downstream of the paddle block, consuming paddle centre coordinates and the pause switch, and owns the ball position, wall and paddle bounces, point detection, scoring and serve timing. It produces the ball pixel-hit signal and colour for the VGA mixer, and the scores and point pulses for the score display and LEDs. All motion advances on the 1 ms game tick clock used by the paddle block.

## Interface
- H_ACTIVE, 640, visible width in pixels
- V_ACTIVE, 480, visible height in pixels
- BALL_HALF, 4, half side of the square ball; ball is 2*BALL_HALF pixels square
- PADDLE_HALF_W, 3, paddle half width, matching the paddle block
- PADDLE_HALF_H, 30, paddle half height, matching the paddle block
- SERVE_TICKS, 1000, ticks the ball rests at centre before each serve
- WIN_SCORE, 7, score that ends the game
- clk_1ms  input  1  game tick clock; all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- switch  input  1  pause; 1 freezes all state
- x, y  input  10 each  current VGA pixel coordinate
- x_paddle1, y_paddle1, x_paddle2, y_paddle2  input  10 each  paddle centres from the paddle block
- ball_on  output  1  combinational: pixel (x,y) lies inside the ball
- rgb_ball  output  12  constant 12'hFF0
- x_ball, y_ball  output  10 each  ball centre (registered)
- score1, score2  output  4 each  player scores (registered)
- point_p1, point_p2  output  1 each  one-tick pulse when the player scores
- game_over  output  1  high once either score equals WIN_SCORE

## Operation
- States: SERVE, PLAY, SCORED, OVER. Direction bits: dir_x (1 = right), dir_y (1 = down). Counter: serve_cnt.
- Reset (asynchronous): state=SERVE, serve_cnt=0, x_ball=H_ACTIVE/2 (320), y_ball=V_ACTIVE/2 (240), dir_x=1, dir_y=1, scores 0, point pulses 0, game_over 0.
- switch=1 in any state: nothing changes, including serve_cnt and the point pulses (pulses are cleared on entry to the freeze). Reset still acts.
- SERVE: the ball is held at centre and serve_cnt increments. When serve_cnt==SERVE_TICKS-1, serve_cnt clears and the state goes to PLAY. The ball therefore rests for exactly SERVE_TICKS unpaused ticks.
- PLAY: each tick the ball moves 1 pixel in x and 1 pixel in y according to the direction bits. Edges are L=x_ball-BALL_HALF, R=x_ball+BALL_HALF, T=y_ball-BALL_HALF, B=y_ball+BALL_HALF.
  - Vertical overlap with paddle n, computed at 11 bits with no underflow: B > y_paddlen-PADDLE_HALF_H and T < y_paddlen+PADDLE_HALF_H.
  - Miss left: dir_x=0 and L==0. Player 2 scores: score2+1, point_p2=1 for one tick, state goes to SCORED, and no move is made this tick.
  - Miss right: dir_x=1 and R==H_ACTIVE-1. Player 1 scores, symmetrically.
  - Paddle 1 hit: dir_x=0, L==x_paddle1+PADDLE_HALF_W+1, and vertical overlap. Set dir_x=1; x moves +1 this tick.
  - Paddle 2 hit: dir_x=1, R==x_paddle2-PADDLE_HALF_W-1, and vertical overlap. Set dir_x=0; x moves -1 this tick.
  - Top wall: dir_y=0 and T==0. Set dir_y=1; y moves +1 this tick. Bottom wall: dir_y=1 and B==V_ACTIVE-1. Set dir_y=0; y moves -1 this tick.
  - The x and y events are evaluated independently and both apply in the same tick. A miss takes priority over every other event: on a miss the y update is also suppressed.
- SCORED (one tick): recentre the ball to (320,240), set dir_x toward the player who lost the point (the scorer's opponent), keep dir_y, and clear point pulses. If either score==WIN_SCORE, go to OVER; otherwise go to SERVE.
- OVER: game_over=1, the ball is frozen at centre, and ball_on=0. Only reset leaves OVER.
- Scores never exceed WIN_SCORE. No increment occurs outside PLAY.
- ball_on = (state!=OVER) and x >= L and x < R and y >= T and y < B.

## Timing
- A miss detected at tick N gives score and pulse visible after edge N. SCORED occupies tick N+1, and SERVE is entered after N+1. The next movement happens SERVE_TICKS ticks later.
- point_p1 and point_p2 are exactly one unpaused tick wide. They are never both high.
- game_over rises on the edge leaving SCORED.
- Outputs change only on clk_1ms edges or on reset assertion. ball_on is purely combinational from registered position and the x/y inputs.
- Reset asserted mid-PLAY or mid-SERVE returns all outputs to reset values immediately, with no clock needed.

## Test plan
- Bench uses SERVE_TICKS=4. Reset, then release: x_ball=320 and y_ball=240 for 4 ticks. Then tick 5 gives (321,241).
- Top bounce: force the ball to y_ball=4, dir_y=0 (T==0). Next tick gives y_ball=5, dir_y=1. x is unaffected.
- Paddle 1 hit: x_paddle1=19, y_paddle1=240, ball at (27,240) moving left. Next tick gives x_ball=28, dir_x=1, with no score change.
- Left miss: paddle 1 at y=60, ball at (4,400) moving left. Next tick: score2=1, point_p2=1 for one tick, x_ball is unchanged. The tick after: ball at (320,240), dir_x=0.
- switch=1 for 10 ticks during PLAY: x_ball, y_ball, serve_cnt and scores are unchanged. After release, motion resumes from the same position.
- score1=6, then a right miss: score1=7. After SCORED, game_over=1, ball_on=0, and the state holds until reset. Asserting reset with no clock edge clears everything.
